// File: rtl/viterbi_traceback.sv
// viterbi_traceback: survivor-memory traceback stage of a Viterbi decoder.
// A frame of survivor decision rows is stored during FILL and walked
// backwards during TRACE; the decoded bits are then streamed out in
// forward order through a valid/ready handshake.
// Optional feature: define VITERBI_TB_BEST_STATE_EN to start traceback
// from best_state_i (unterminated frames) instead of state 0.
module viterbi_traceback #(
    parameter int unsigned MAX_LEN = 256
) (
    input  logic        clk_i,
    input  logic        rst_an_i,
    input  logic        rst_sync_i,
    input  logic        start_i,
    input  logic [10:0] frame_len_i,
    input  logic [1:0]  register_num_i,
    input  logic [63:0] surv_i,
    input  logic        surv_valid_i,
    input  logic [5:0]  best_state_i,
    output logic        ready_o,
    output logic        dec_bit_o,
    output logic        dec_valid_o,
    output logic        dec_last_o,
    input  logic        dec_ready_i,
    output logic        overflow_o
);

    localparam int unsigned AW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_TRACE,
        ST_OUT
    } state_t;

    state_t state_q, state_d;

    logic [AW-1:0] t_q;
    logic [AW-1:0] k_q;
    logic [AW-1:0] k_nxt;
    logic [AW-1:0] last_q;
    logic [AW-1:0] len_last;
    logic [1:0]    reg_q;
    logic [5:0]    s_q;
    logic [5:0]    s_nxt;
    logic [5:0]    s_mask;
    logic [5:0]    s_init;
    logic [63:0]   surv_rd;
    logic          surv_d;
    logic          trace_bit;
    logic          fill_done;
    logic          trace_done;
    logic          out_done;

    logic          dec_bit_q;
    logic          dec_valid_q;
    logic          dec_last_q;
    logic          overflow_q;

    logic [63:0]   surv_mem [MAX_LEN];
    logic          dec_buf  [MAX_LEN];

    // Frame length decode, survivor read and single traceback step
    always_comb begin
        if (frame_len_i == '0 || frame_len_i > 11'(MAX_LEN)) begin
            len_last = '1;
        end else begin
            len_last = AW'(frame_len_i - 11'd1);
        end
        s_mask    = 6'h3F >> (2'd3 - reg_q);
        surv_rd   = surv_mem[t_q];
        surv_d    = surv_rd[s_q];
        trace_bit = s_q[3'd2 + 3'(reg_q)];
        s_nxt     = {s_q[4:0], surv_d} & s_mask;
        k_nxt     = k_q + 1'b1;
    end

`ifdef VITERBI_TB_BEST_STATE_EN
    assign s_init = best_state_i & s_mask;
`else
    logic unused_best_state;
    assign unused_best_state = ^best_state_i;
    assign s_init = '0;
`endif

    assign fill_done  = (state_q == ST_FILL) && surv_valid_i && (t_q == last_q);
    assign trace_done = (state_q == ST_TRACE) && (t_q == '0);
    assign out_done   = (state_q == ST_OUT) && dec_valid_q && dec_ready_i && dec_last_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; synchronous reset overrides any transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i)    state_d = ST_FILL;
            ST_FILL:  if (fill_done)  state_d = ST_TRACE;
            ST_TRACE: if (trace_done) state_d = ST_OUT;
            ST_OUT:   if (out_done)   state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
        if (rst_sync_i) begin
            state_d = ST_IDLE;
        end
    end

    // Output decode
    always_comb begin
        ready_o     = (state_q == ST_FILL);
        dec_bit_o   = dec_bit_q;
        dec_valid_o = dec_valid_q;
        dec_last_o  = dec_last_q;
        overflow_o  = overflow_q;
    end

    // Counters, traceback state, registered output stage and overflow flag.
    // The output stage loads entry k one cycle after OUT is entered, which
    // gives the single transition cycle ahead of the first decoded bit.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            t_q         <= '0;
            k_q         <= '0;
            last_q      <= '0;
            reg_q       <= '0;
            s_q         <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (rst_sync_i) begin
            t_q         <= '0;
            k_q         <= '0;
            last_q      <= '0;
            reg_q       <= '0;
            s_q         <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
            dec_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (surv_valid_i && (state_q != ST_FILL)) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        last_q <= len_last;
                        reg_q  <= register_num_i;
                        t_q    <= '0;
                        k_q    <= '0;
                    end
                end
                ST_FILL: begin
                    if (surv_valid_i) begin
                        if (t_q == last_q) begin
                            s_q <= s_init;
                        end else begin
                            t_q <= t_q + 1'b1;
                        end
                    end
                end
                ST_TRACE: begin
                    s_q <= s_nxt;
                    if (t_q == '0) begin
                        k_q <= '0;
                    end else begin
                        t_q <= t_q - 1'b1;
                    end
                end
                ST_OUT: begin
                    if (!dec_valid_q) begin
                        dec_bit_q   <= dec_buf[k_q];
                        dec_valid_q <= 1'b1;
                        dec_last_q  <= (k_q == last_q);
                    end else if (dec_ready_i) begin
                        if (dec_last_q) begin
                            dec_bit_q   <= 1'b0;
                            dec_valid_q <= 1'b0;
                            dec_last_q  <= 1'b0;
                        end else begin
                            k_q        <= k_nxt;
                            dec_bit_q  <= dec_buf[k_nxt];
                            dec_last_q <= (k_nxt == last_q);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Survivor and decode buffers; contents survive reset by design
    always_ff @(posedge clk_i) begin
        if (!rst_sync_i && (state_q == ST_FILL) && surv_valid_i) begin
            surv_mem[t_q] <= surv_i;
        end
        if (!rst_sync_i && (state_q == ST_TRACE)) begin
            dec_buf[t_q] <= trace_bit;
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb_viterbi_traceback: directed + randomized checks of viterbi_traceback
// against a behavioural traceback model and a K=7 encoder/ACS reference.
module tb_viterbi_traceback;

    localparam int MAX = 64;

    logic        clk = 1'b0;
    logic        rst_an = 1'b1;
    logic        rst_sync = 1'b0;
    logic        start = 1'b0;
    logic [10:0] frame_len = '0;
    logic [1:0]  reg_num = '0;
    logic [63:0] surv = '0;
    logic        surv_valid = 1'b0;
    logic [5:0]  best_state = '0;
    logic        ready;
    logic        dec_bit;
    logic        dec_valid;
    logic        dec_last;
    logic        dec_ready = 1'b0;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] rows [MAX];
    logic        exp_bits [MAX];
    logic        last_bit_seen;

    viterbi_traceback #(.MAX_LEN(MAX)) dut (
        .clk_i         (clk),
        .rst_an_i      (rst_an),
        .rst_sync_i    (rst_sync),
        .start_i       (start),
        .frame_len_i   (frame_len),
        .register_num_i(reg_num),
        .surv_i        (surv),
        .surv_valid_i  (surv_valid),
        .best_state_i  (best_state),
        .ready_o       (ready),
        .dec_bit_o     (dec_bit),
        .dec_valid_o   (dec_valid),
        .dec_last_o    (dec_last),
        .dec_ready_i   (dec_ready),
        .overflow_o    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_len(input int len_code);
        return (len_code == 0 || len_code > MAX) ? MAX : len_code;
    endfunction

    function automatic int start_state(input int best);
`ifdef VITERBI_TB_BEST_STATE_EN
        return best;
`else
        return 0 * best;
`endif
    endfunction

    task automatic random_rows();
        for (int t = 0; t < MAX; t++) rows[t] = {$urandom, $urandom};
    endtask

    // Walk the stored decisions backwards from the chosen final state
    task automatic model_trace(input int L, input int rn, input int st);
        int m, mask, s;
        m    = 3 + rn;
        mask = (1 << m) - 1;
        s    = st & mask;
        for (int t = L - 1; t >= 0; t--) begin
            exp_bits[t] = s[m-1];
            s = ((s << 1) | int'(rows[t][s])) & mask;
        end
    endtask

    // 26 random bits + 6 zero tail, rate-1/2 K=7 (0x6D/0x4F), hard-decision
    // ACS producing survivor rows; expected bits are the message itself
    task automatic gen_k7_frame();
        int metric [64];
        int nm [64];
        int enc, u, r, c0, c1, pb, uu, p, rr, cand, bestm, d;
        enc = 0;
        for (int i = 0; i < 64; i++) metric[i] = (i == 0) ? 0 : 10000;
        for (int t = 0; t < 32; t++) begin
            u  = (t < 26) ? int'($urandom_range(0, 1)) : 0;
            r  = (u << 6) | enc;
            c0 = $countones(r & 'h6D) & 1;
            c1 = $countones(r & 'h4F) & 1;
            exp_bits[t] = u[0];
            enc = r >> 1;
            for (int s = 0; s < 64; s++) begin
                pb = (s << 1) & 63;
                uu = s >> 5;
                bestm = 0;
                d = 0;
                for (int b = 0; b < 2; b++) begin
                    p  = pb | b;
                    rr = (uu << 6) | p;
                    cand = metric[p]
                         + ((($countones(rr & 'h6D) & 1) != c0) ? 1 : 0)
                         + ((($countones(rr & 'h4F) & 1) != c1) ? 1 : 0);
                    if (b == 0 || cand < bestm) begin
                        bestm = cand;
                        d = b;
                    end
                end
                nm[s] = bestm;
                rows[t][s] = d[0];
            end
            for (int s = 0; s < 64; s++) metric[s] = nm[s];
        end
    endtask

    // One full frame: FILL with random gaps, latency check, OUT with the
    // chosen dec_ready pattern (0: always, 1: toggling, 2: random)
    task automatic run_frame(input int len_code, input int rn, input logic [5:0] best,
                             input int out_mode, input bit inj_ovf, input bit start_at_end,
                             input string tag);
        int L, cnt, idx, guard;
        bit stalled;
        logic pb, pl, rdy;
        L = eff_len(len_code);
        frame_len  = 11'(len_code);
        reg_num    = 2'(rn);
        best_state = best;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_fill"}, 32'(ready), 32'd1);
        idx = 0;
        while (idx < L) begin
            if ($urandom_range(0, 3) == 0) begin
                surv_valid = 1'b0;
                surv = {$urandom, $urandom};
            end else begin
                surv_valid = 1'b1;
                surv = rows[idx];
                idx++;
            end
            tick();
        end
        surv_valid = 1'b0;
        cnt = 0;
        while (dec_valid !== 1'b1 && cnt < 4 * MAX) begin
            if (inj_ovf && cnt == 1) begin
                surv_valid = 1'b1;
                surv = '1;
            end
            tick();
            surv_valid = 1'b0;
            cnt++;
            if (cnt == 1) check({tag, "_ready_trace"}, 32'(ready), 32'd0);
        end
        check({tag, "_latency"}, 32'(cnt), 32'(L + 1));
        idx = 0;
        guard = 0;
        stalled = 0;
        pb = 1'b0;
        pl = 1'b0;
        while (idx < L && guard < 4 * MAX + 20) begin
            if (stalled) begin
                check({tag, "_stall_valid"}, 32'(dec_valid), 32'd1);
                check({tag, "_stall_bit"}, 32'(dec_bit), 32'(pb));
                check({tag, "_stall_last"}, 32'(dec_last), 32'(pl));
            end
            case (out_mode)
                0:       rdy = 1'b1;
                1:       rdy = guard[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dec_ready = rdy;
            stalled = 0;
            if (dec_valid === 1'b1) begin
                if (rdy) begin
                    check({tag, "_bit"}, 32'(dec_bit), 32'(exp_bits[idx]));
                    check({tag, "_last"}, 32'(dec_last), 32'(idx == L - 1));
                    last_bit_seen = dec_bit;
                    if (idx == L - 1 && start_at_end) start = 1'b1;
                    idx++;
                end else begin
                    stalled = 1;
                    pb = dec_bit;
                    pl = dec_last;
                end
            end
            tick();
            start = 1'b0;
            guard++;
        end
        dec_ready = 1'b0;
        check({tag, "_bits_out"}, 32'(idx), 32'(L));
        check({tag, "_valid_idle"}, 32'(dec_valid), 32'd0);
        check({tag, "_ready_idle"}, 32'(ready), 32'd0);
    endtask

    initial begin
        int hits;

        // Asynchronous reset
        #2 rst_an = 1'b0;
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(dec_valid), 32'd0);
        check("rst_bit", 32'(dec_bit), 32'd0);
        check("rst_last", 32'(dec_last), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        repeat (3) tick();
        rst_an = 1'b1;
        tick();

        // All-zero survivors, 8 states, L=8
        for (int t = 0; t < MAX; t++) rows[t] = '0;
        for (int t = 0; t < MAX; t++) exp_bits[t] = 1'b0;
        run_frame(8, 0, 6'd0, 0, 1'b0, 1'b0, "zero8");
        check("zero8_overflow", 32'(overflow), 32'd0);

        // K=7 encoded message through golden ACS survivors
        gen_k7_frame();
        run_frame(32, 3, 6'd0, 0, 1'b0, 1'b0, "k7msg");

        // Random survivors across state counts and lengths
        for (int i = 0; i < 4; i++) begin
            int rn, len, bs;
            rn  = int'($urandom_range(0, 3));
            len = int'($urandom_range(1, MAX));
            bs  = int'($urandom_range(0, 63));
            random_rows();
            model_trace(len, rn, start_state(bs));
            run_frame(len, rn, 6'(bs), 2, 1'b0, 1'b0, "rand");
        end

        // Toggling dec_ready; start_i on the final handshake is ignored
        random_rows();
        model_trace(20, 2, start_state(5));
        run_frame(20, 2, 6'd5, 1, 1'b0, 1'b1, "toggle");
        tick();
        check("toggle_no_restart", 32'(ready), 32'd0);

        // Survivor offered during TRACE sets sticky overflow
        random_rows();
        model_trace(12, 1, start_state(3));
        run_frame(12, 1, 6'd3, 0, 1'b1, 1'b0, "ovf");
        repeat (3) tick();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Synchronous reset mid-TRACE, with a competing start_i
        random_rows();
        frame_len = 11'd16;
        reg_num = 2'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            surv = rows[t];
            surv_valid = 1'b1;
            tick();
        end
        surv_valid = 1'b0;
        repeat (6) tick();
        check("srst_ovf_before", 32'(overflow), 32'd1);
        rst_sync = 1'b1;
        start = 1'b1;
        tick();
        rst_sync = 1'b0;
        start = 1'b0;
        check("srst_valid", 32'(dec_valid), 32'd0);
        check("srst_ready", 32'(ready), 32'd0);
        check("srst_overflow", 32'(overflow), 32'd0);
        hits = 0;
        repeat (40) begin
            tick();
            if (dec_valid !== 1'b0) hits++;
        end
        check("srst_no_output", 32'(hits), 32'd0);
        random_rows();
        model_trace(16, 1, start_state(9));
        run_frame(16, 1, 6'd9, 2, 1'b0, 1'b0, "post_srst");

        // Length boundaries: 0 and above MAX both mean MAX; single stage
        random_rows();
        model_trace(MAX, 3, start_state(17));
        run_frame(0, 3, 6'd17, 0, 1'b0, 1'b0, "len0");
        random_rows();
        model_trace(MAX, 0, start_state(6));
        run_frame(MAX + 5, 0, 6'd6, 2, 1'b0, 1'b0, "lenbig");
        random_rows();
        model_trace(1, 2, start_state(31));
        run_frame(1, 2, 6'd31, 0, 1'b0, 1'b0, "len1");

`ifdef VITERBI_TB_BEST_STATE_EN
        // Unterminated frame started from best state 0x2A
        random_rows();
        model_trace(24, 3, 'h2A);
        run_frame(24, 3, 6'h2A, 0, 1'b0, 1'b0, "best2a");
        check("best2a_first_trace_bit", 32'(last_bit_seen), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
